// File: rtl/parity_frame_arbiter.sv
// ---------------------------------------------------------------------------
// parity_frame_arbiter
//
// Shares one XOR-reduction parity unit among NREQ requesters, one word per
// cycle. Each requester streams a frame of words ending with a last marker.
// The block keeps a running parity bit per requester. When the last word of
// a frame is accepted, the frame parity and the requester index go into a
// valid/ready output register.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   WIDTH  data word width
//   ODD    0 = even parity (XOR of all frame bits), 1 = inverted
//   IDW    result ID width, derived from NREQ
//
// Ports
//   clk_pad         clock, rising edge
//   rst_pad         synchronous active-high reset
//   req_pad         per-requester word valid
//   last_pad        per-requester end-of-frame marker (qualified by req_pad)
//   data_pad        word of requester i at [i*WIDTH +: WIDTH]
//   gnt_pad         one-hot (or zero) accept, combinational
//   res_valid_pad   frame result held in the output register
//   res_id_pad      requester index of the held result
//   res_parity_pad  frame parity of the held result
//   res_ready_pad   downstream accepts the held result
//   busy_pad        any frame open, or a result held
// ---------------------------------------------------------------------------
module parity_frame_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter bit ODD   = 1'b0,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk_pad,
    input  logic                  rst_pad,
    input  logic [NREQ-1:0]       req_pad,
    input  logic [NREQ-1:0]       last_pad,
    input  logic [NREQ*WIDTH-1:0] data_pad,
    output logic [NREQ-1:0]       gnt_pad,
    output logic                  res_valid_pad,
    output logic [IDW-1:0]        res_id_pad,
    output logic                  res_parity_pad,
    input  logic                  res_ready_pad,
    output logic                  busy_pad
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_e;

    out_state_e r_state;
    out_state_e w_state_nxt;

    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] r_acc;
    logic [NREQ-1:0] r_open;
    logic [IDW-1:0]  r_res_id;
    logic            r_res_parity;

    logic            w_out_free;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_word_par;
    logic            w_gnt_any;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_gnt_last;
    logic            w_gnt_wpar;
    logic            w_gnt_acc;
    logic            w_last_gnt;
    logic [IDW-1:0]  w_ptr_nxt;
    int              w_scan_sum;
    logic [IDW-1:0]  w_scan_idx;

    assign res_valid_pad  = (r_state == S_FULL);
    assign res_id_pad     = r_res_id;
    assign res_parity_pad = r_res_parity;
    assign busy_pad       = (|r_open) | res_valid_pad;

    // A last word may only be taken when the output register can accept it
    // this cycle; non-last words only touch the accumulators and never stall.
    assign w_out_free = ~res_valid_pad | res_ready_pad;
    assign w_elig     = req_pad & (~last_pad | {NREQ{w_out_free}});

    // Word parity is reduced per requester, then selected by the grant index,
    // so only a 1-bit mux sits behind the arbiter.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default first; a path that leaves one unassigned infers a latch.
        w_word_par = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_word_par[i] = ^data_pad[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin scan starting at r_ptr, wrapping modulo NREQ. The first
    // eligible index wins; the scan is suppressed entirely during reset.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_sum = 0;
        w_scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_sum = int'(r_ptr) + k;
            if (w_scan_sum >= NREQ) begin
                w_scan_sum = w_scan_sum - NREQ;
            end
            w_scan_idx = IDW'(w_scan_sum);
            if (!w_gnt_any && !rst_pad && w_elig[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    always_comb begin
        gnt_pad = '0;
        if (w_gnt_any) begin
            gnt_pad[w_gnt_idx] = 1'b1;
        end
    end

    assign w_gnt_last = last_pad[w_gnt_idx];
    assign w_gnt_wpar = w_word_par[w_gnt_idx];
    assign w_gnt_acc  = r_acc[w_gnt_idx];
    assign w_last_gnt = w_gnt_any & w_gnt_last;
    assign w_ptr_nxt  = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Output register FSM. A last-word grant while FULL is only possible when
    // the held result is being handshaken, so the new result simply replaces
    // it and the state stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_last_gnt) w_state_nxt = S_FULL;
            S_FULL:  if (res_ready_pad && !w_last_gnt) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_pad) begin
        // NOTE: the per-requester accumulators are ordinary flops, not a RAM,
        // so they are cleared by reset; a mid-frame reset must drop every
        // partial frame.
        if (rst_pad) begin
            r_state      <= S_EMPTY;
            r_ptr        <= '0;
            r_acc        <= '0;
            r_open       <= '0;
            r_res_id     <= '0;
            r_res_parity <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            if (w_gnt_any) begin
                r_ptr <= w_ptr_nxt;
                if (w_gnt_last) begin
                    r_res_id             <= w_gnt_idx;
                    r_res_parity         <= w_gnt_acc ^ w_gnt_wpar ^ ODD;
                    r_acc[w_gnt_idx]     <= 1'b0;
                    r_open[w_gnt_idx]    <= 1'b0;
                end else begin
                    r_acc[w_gnt_idx]     <= w_gnt_acc ^ w_gnt_wpar;
                    r_open[w_gnt_idx]    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_arbiter
//
// Directed bench for parity_frame_arbiter with NREQ=4, WIDTH=16. Two copies
// of the design share every input: one with even parity, one with ODD=1, so
// each frame is checked under both senses. Inputs change 1 time unit after a
// rising edge; combinational grants are sampled 1 unit later, registered
// outputs 1 unit after the following edge.
// ---------------------------------------------------------------------------
module tb_parity_frame_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                  clk_pad;
    logic                  rst_pad;
    logic [NREQ-1:0]       req_pad;
    logic [NREQ-1:0]       last_pad;
    logic [NREQ*WIDTH-1:0] data_pad;
    logic                  res_ready_pad;

    logic [NREQ-1:0]       gnt_pad;
    logic                  res_valid_pad;
    logic [IDW-1:0]        res_id_pad;
    logic                  res_parity_pad;
    logic                  busy_pad;

    logic [NREQ-1:0]       gnt_odd;
    logic                  valid_odd;
    logic [IDW-1:0]        id_odd;
    logic                  parity_odd;
    logic                  busy_odd;

    int n_assert;
    int n_fail;

    parity_frame_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ODD(1'b0)) dut (
        .clk_pad(clk_pad), .rst_pad(rst_pad), .req_pad(req_pad),
        .last_pad(last_pad), .data_pad(data_pad), .gnt_pad(gnt_pad),
        .res_valid_pad(res_valid_pad), .res_id_pad(res_id_pad),
        .res_parity_pad(res_parity_pad), .res_ready_pad(res_ready_pad),
        .busy_pad(busy_pad)
    );

    parity_frame_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ODD(1'b1)) dut_odd (
        .clk_pad(clk_pad), .rst_pad(rst_pad), .req_pad(req_pad),
        .last_pad(last_pad), .data_pad(data_pad), .gnt_pad(gnt_odd),
        .res_valid_pad(valid_odd), .res_id_pad(id_odd),
        .res_parity_pad(parity_odd), .res_ready_pad(res_ready_pad),
        .busy_pad(busy_odd)
    );

    initial clk_pad = 1'b0;
    always #5 clk_pad = ~clk_pad;

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk_pad);
        #1;
    endtask

    task automatic idle();
        req_pad  = '0;
        last_pad = '0;
        data_pad = '0;
    endtask

    // Drive one word for requester r; other requesters are left as they are.
    task automatic put(input int r, input logic lst, input logic [WIDTH-1:0] w);
        req_pad[r]                 = 1'b1;
        last_pad[r]                = lst;
        data_pad[r*WIDTH +: WIDTH] = w;
    endtask

    task automatic do_reset();
        idle();
        rst_pad = 1'b1;
        tick();
        rst_pad = 1'b0;
    endtask

    task automatic test_reset();
        rst_pad       = 1'b1;
        res_ready_pad = 1'b1;
        req_pad       = '1;
        last_pad      = '1;
        data_pad      = '0;
        #1;
        n_assert++; if (gnt_pad !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_forced: got %b expected 0000", gnt_pad); end
        tick();
        tick();
        n_assert++; if (gnt_pad !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt_pad); end
        n_assert++; if (res_valid_pad !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", res_valid_pad); end
        n_assert++; if (res_id_pad !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b expected 0", res_parity_pad); end
        n_assert++; if (busy_pad !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_pad); end
        idle();
        rst_pad = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_gnt [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        res_ready_pad = 1'b1;
        for (int r = 0; r < NREQ; r++) put(r, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_assert++; if (gnt_pad !== exp_gnt[i]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt_pad, exp_gnt[i]); end
            tick();
        end
        idle();
        #1;
        n_assert++; if (busy_pad !== 1'b1) begin n_fail++; $display("FAIL rr_busy_open: got %b expected 1", busy_pad); end
        do_reset();
    endtask

    task automatic test_single_word();
        res_ready_pad = 1'b1;
        put(2, 1'b1, 16'h0007);
        #1;
        n_assert++; if (gnt_pad !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b expected 0100", gnt_pad); end
        tick();
        // Back-to-back second frame from the same requester.
        put(2, 1'b1, 16'h0003);
        n_assert++; if (res_valid_pad !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", res_valid_pad); end
        n_assert++; if (res_id_pad !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d expected 2", res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b1) begin n_fail++; $display("FAIL single_par7: got %b expected 1", res_parity_pad); end
        n_assert++; if (parity_odd !== 1'b0) begin n_fail++; $display("FAIL single_par7_odd: got %b expected 0", parity_odd); end
        #1;
        n_assert++; if (gnt_pad !== 4'b0100) begin n_fail++; $display("FAIL single_gnt_b2b: got %b expected 0100", gnt_pad); end
        tick();
        idle();
        n_assert++; if (res_valid_pad !== 1'b1) begin n_fail++; $display("FAIL single_valid_b2b: got %b expected 1", res_valid_pad); end
        n_assert++; if (res_parity_pad !== 1'b0) begin n_fail++; $display("FAIL single_par3: got %b expected 0", res_parity_pad); end
        n_assert++; if (parity_odd !== 1'b1) begin n_fail++; $display("FAIL single_par3_odd: got %b expected 1", parity_odd); end
        tick();
        n_assert++; if (res_valid_pad !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b expected 0", res_valid_pad); end
    endtask

    task automatic test_multi_word();
        logic [WIDTH-1:0] words [3];
        words = '{16'h0001, 16'h0001, 16'h8000};
        res_ready_pad = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            put(0, (i == 2), words[i]);
            #1;
            n_assert++; if (gnt_pad !== 4'b0001) begin n_fail++; $display("FAIL multi_gnt[%0d]: got %b expected 0001", i, gnt_pad); end
            tick();
            n_assert++; if (busy_pad !== 1'b1) begin n_fail++; $display("FAIL multi_busy[%0d]: got %b expected 1", i, busy_pad); end
            if (i < 2) begin
                n_assert++; if (res_valid_pad !== 1'b0) begin n_fail++; $display("FAIL multi_early_valid[%0d]: got %b expected 0", i, res_valid_pad); end
            end
        end
        idle();
        n_assert++; if (res_valid_pad !== 1'b1) begin n_fail++; $display("FAIL multi_valid: got %b expected 1", res_valid_pad); end
        n_assert++; if (res_id_pad !== 2'd0) begin n_fail++; $display("FAIL multi_id: got %0d expected 0", res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b1) begin n_fail++; $display("FAIL multi_par: got %b expected 1", res_parity_pad); end
        n_assert++; if (parity_odd !== 1'b0) begin n_fail++; $display("FAIL multi_par_odd: got %b expected 0", parity_odd); end
        tick();
        n_assert++; if (busy_pad !== 1'b0) begin n_fail++; $display("FAIL multi_busy_end: got %b expected 0", busy_pad); end
        n_assert++; if (res_valid_pad !== 1'b0) begin n_fail++; $display("FAIL multi_single_result: got %b expected 0", res_valid_pad); end
    endtask

    task automatic test_backpressure();
        // Load a held result: id 0, parity of 0x0001 = 1.
        res_ready_pad = 1'b0;
        put(0, 1'b1, 16'h0001);
        #1;
        n_assert++; if (gnt_pad !== 4'b0001) begin n_fail++; $display("FAIL bp_load_gnt: got %b expected 0001", gnt_pad); end
        tick();
        idle();
        put(1, 1'b1, 16'h0003);
        put(3, 1'b0, 16'h0001);
        #1;
        n_assert++; if (gnt_pad !== 4'b1000) begin n_fail++; $display("FAIL bp_stall_gnt: got %b expected 1000", gnt_pad); end
        tick();
        n_assert++; if (res_valid_pad !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b expected 1", res_valid_pad); end
        n_assert++; if (res_id_pad !== 2'd0) begin n_fail++; $display("FAIL bp_hold_id: got %0d expected 0", res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b1) begin n_fail++; $display("FAIL bp_hold_par: got %b expected 1", res_parity_pad); end
        res_ready_pad = 1'b1;
        req_pad[3]    = 1'b0;
        #1;
        n_assert++; if (gnt_pad !== 4'b0010) begin n_fail++; $display("FAIL bp_release_gnt: got %b expected 0010", gnt_pad); end
        tick();
        idle();
        n_assert++; if (res_valid_pad !== 1'b1) begin n_fail++; $display("FAIL bp_replace_valid: got %b expected 1", res_valid_pad); end
        n_assert++; if (res_id_pad !== 2'd1) begin n_fail++; $display("FAIL bp_replace_id: got %0d expected 1", res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b0) begin n_fail++; $display("FAIL bp_replace_par: got %b expected 0", res_parity_pad); end
        n_assert++; if (parity_odd !== 1'b1) begin n_fail++; $display("FAIL bp_replace_par_odd: got %b expected 1", parity_odd); end
        // Requester 3 still has an open frame with accumulated parity 1.
        put(3, 1'b1, 16'h0000);
        #1;
        n_assert++; if (gnt_pad !== 4'b1000) begin n_fail++; $display("FAIL bp_close3_gnt: got %b expected 1000", gnt_pad); end
        tick();
        idle();
        n_assert++; if (res_id_pad !== 2'd3) begin n_fail++; $display("FAIL bp_close3_id: got %0d expected 3", res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b1) begin n_fail++; $display("FAIL bp_close3_par: got %b expected 1", res_parity_pad); end
        tick();
        n_assert++; if (busy_pad !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %b expected 0", busy_pad); end
    endtask

    task automatic test_interleaved();
        res_ready_pad = 1'b1;
        put(0, 1'b0, 16'hFFFF);
        #1;
        n_assert++; if (gnt_pad !== 4'b0001) begin n_fail++; $display("FAIL il_gnt0a: got %b expected 0001", gnt_pad); end
        tick();
        idle();
        put(1, 1'b0, 16'h0003);
        #1;
        n_assert++; if (gnt_pad !== 4'b0010) begin n_fail++; $display("FAIL il_gnt1a: got %b expected 0010", gnt_pad); end
        tick();
        idle();
        put(0, 1'b1, 16'h0001);
        tick();
        idle();
        put(1, 1'b1, 16'h0004);
        n_assert++; if (res_valid_pad !== 1'b1 || res_id_pad !== 2'd0) begin n_fail++; $display("FAIL il_res0_id: got valid %b id %0d expected valid 1 id 0", res_valid_pad, res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b1) begin n_fail++; $display("FAIL il_res0_par: got %b expected 1", res_parity_pad); end
        tick();
        idle();
        n_assert++; if (res_valid_pad !== 1'b1 || res_id_pad !== 2'd1) begin n_fail++; $display("FAIL il_res1_id: got valid %b id %0d expected valid 1 id 1", res_valid_pad, res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b1) begin n_fail++; $display("FAIL il_res1_par: got %b expected 1", res_parity_pad); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        res_ready_pad = 1'b1;
        put(0, 1'b0, 16'h0001);
        tick();
        n_assert++; if (busy_pad !== 1'b1) begin n_fail++; $display("FAIL rmf_busy_open: got %b expected 1", busy_pad); end
        rst_pad = 1'b1;
        put(0, 1'b1, 16'h0000);
        #1;
        n_assert++; if (gnt_pad !== 4'b0000) begin n_fail++; $display("FAIL rmf_gnt_in_reset: got %b expected 0000", gnt_pad); end
        tick();
        rst_pad = 1'b0;
        idle();
        n_assert++; if ({res_valid_pad, res_id_pad, res_parity_pad, busy_pad} !== 5'b0) begin n_fail++; $display("FAIL rmf_outputs_zero: got %b expected 00000", {res_valid_pad, res_id_pad, res_parity_pad, busy_pad}); end
        put(0, 1'b1, 16'h0000);
        tick();
        idle();
        n_assert++; if (res_valid_pad !== 1'b1 || res_id_pad !== 2'd0) begin n_fail++; $display("FAIL rmf_res_id: got valid %b id %0d expected valid 1 id 0", res_valid_pad, res_id_pad); end
        n_assert++; if (res_parity_pad !== 1'b0) begin n_fail++; $display("FAIL rmf_res_par: got %b expected 0", res_parity_pad); end
        n_assert++; if (parity_odd !== 1'b1) begin n_fail++; $display("FAIL rmf_res_par_odd: got %b expected 1", parity_odd); end
        tick();
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst_pad       = 1'b1;
        res_ready_pad = 1'b1;
        idle();
        test_reset();
        test_round_robin();
        test_single_word();
        test_multi_word();
        test_backpressure();
        test_interleaved();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_arbiter.md
# parity_frame_arbiter

Shares one WIDTH-bit XOR-reduction parity unit among NREQ requesters on a word-per-cycle basis. Each requester streams a frame of words with a last marker, and the block keeps a per-requester running parity. On the last word it delivers one frame-parity result, tagged with the requester ID, through a valid/ready output register. The block sits between the requester ports and the downstream checker that consumes parity results.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, data word width
- ODD, 0, parity sense: 0 = even (result = XOR of all frame bits), 1 = odd (result inverted)
- IDW, $clog2(NREQ), result ID width (derived)

Ports:
- clk_pad  in  1  clock; all state updates on the rising edge
- rst_pad  in  1  reset, synchronous, active-high
- req_pad  in  NREQ  per-requester word valid
- last_pad  in  NREQ  per-requester end-of-frame marker, qualified by req_pad
- data_pad  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
- gnt_pad  out  NREQ  one-hot (or zero) accept; a word transfers when req_pad[i] & gnt_pad[i]
- res_valid_pad  out  1  frame result held in the output register
- res_id_pad  out  IDW  requester index of the held result
- res_parity_pad  out  1  frame parity of the held result
- res_ready_pad  in  1  downstream accepts the result when res_valid_pad & res_ready_pad
- busy_pad  out  1  any frame open, or result held

## Operation
- Per-requester state: acc[i] (1 bit, running parity) and open[i] (frame in progress).
- Output register: two-state FSM.
  - EMPTY -> FULL on a last-word grant.
  - FULL -> EMPTY on a handshake with no last-word grant in the same cycle.
  - FULL stays FULL on a handshake plus a simultaneous last-word grant; the new result is loaded.
- out_free = ~res_valid_pad | res_ready_pad.
- Eligibility: elig[i] = req_pad[i] & (~last_pad[i] | out_free).
  - Non-last words are never stalled by output backpressure.
- Arbitration is round-robin. Pointer ptr (IDW bits) marks the highest-priority index. The first elig[i] scanning ptr, ptr+1, ..., wrapping modulo NREQ, is granted.
- After a grant to index g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Non-last granted word w from requester g:
  - acc[g] <= acc[g] ^ (^w)
  - open[g] <= 1
- Last granted word w from requester g:
  - res_parity <= acc[g] ^ (^w) ^ ODD
  - res_id <= g
  - res_valid <= 1
  - acc[g] <= 0, open[g] <= 0
  - A single-word frame (last on the first word) is legal.
- Requesters that are not granted keep acc and open unchanged. A requester may drop req_pad mid-frame; its acc is retained.
- gnt_pad is combinational from req_pad, last_pad, res_valid_pad, res_ready_pad and ptr. It is forced to 0 while rst_pad = 1.
- busy_pad = (|open) | res_valid_pad.

## Timing
- Reset values: gnt_pad = 0, res_valid_pad = 0, res_id_pad = 0, res_parity_pad = 0, busy_pad = 0, ptr = 0, all acc = 0, all open = 0.
- Reset asserted mid-frame discards all partial frames and any held result on the next edge.
- Throughput: one word per cycle total across all requesters.
- Grant latency: the same cycle as req_pad, when the requester is eligible and wins arbitration.
- Result latency: res_valid_pad rises on the edge that accepts the last word, so it is visible the cycle after the grant.
- Back-to-back results: supported with no bubble while res_ready_pad = 1.
- res_id_pad and res_parity_pad hold stable while res_valid_pad = 1 and res_ready_pad = 0.
- Worst-case starvation: a continuously eligible requester is granted within NREQ cycles.

## Test plan
- **Single-word frames.** NREQ=4, WIDTH=16, ODD=0, res_ready_pad = 1.
  - Stimulus: requester 2 sends data 0x0007 with last = 1.
  - Required: gnt_pad = 4'b0100 in the same cycle. Next cycle res_valid_pad = 1, res_id_pad = 2, res_parity_pad = 1.
  - Repeat with 0x0003: res_parity_pad = 0.
- **Multi-word accumulation.**
  - Stimulus: requester 0 sends 0x0001, 0x0001, 0x8000 (last) on consecutive cycles.
  - Required: a single result with res_id_pad = 0 and res_parity_pad = 1. busy_pad = 1 from the first grant until the result handshake.
  - With ODD=1 the same frame gives res_parity_pad = 0.
- **Round-robin fairness.**
  - Stimulus: all four req_pad held high with non-last words, starting from reset.
  - Required: gnt_pad sequence 0001, 0010, 0100, 1000, 0001.
- **Backpressure.**
  - Stimulus: res_ready_pad = 0 while a result is held. Requester 1 presents a last word; requester 3 presents a non-last word.
  - Required: requester 1 is not granted, requester 3 is granted, and the held res_id_pad and res_parity_pad stay unchanged.
  - Raise res_ready_pad: requester 1 is granted in that same cycle, and its result replaces the old one on the next edge with res_valid_pad staying at 1.
- **Interleaved frames.**
  - Stimulus: requesters 0 and 1 alternate words. Requester 0 sends 0xFFFF, 0x0001 (last). Requester 1 sends 0x0003, 0x0004 (last).
  - Required: results (id 0, parity 1) then (id 1, parity 1), with no cross-contamination between accumulators.
- **Reset mid-frame.**
  - Stimulus: requester 0 sends 0x0001 (non-last), then rst_pad is pulsed for 1 cycle, then requester 0 sends 0x0000 (last).
  - Required: all outputs are zero after reset, and the final result has res_parity_pad = 0.
